// File: rtl/ic_sdr_qsram_banked.sv
// Banked single-port SRAM model with an SDR-style command interface,
// fixed read latency and periodic/manual refresh that stalls new commands.
module ic_sdr_qsram_banked #(
    parameter int ADDR_WIDTH       = 10,
    parameter int DATA_WIDTH       = 9,
    parameter int BANKS            = 4,
    parameter int READ_LATENCY     = 2,
    parameter int REFRESH_INTERVAL = 64,
    parameter int REFRESH_CYCLES   = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_enable,
    input  logic                  i_read,
    input  logic                  i_write,
    input  logic                  i_refresh,
    input  logic [ADDR_WIDTH-1:0] i_address,
    input  logic [DATA_WIDTH-1:0] i_writeData,
    output logic [DATA_WIDTH-1:0] o_readData,
    output logic                  o_readValid,
    output logic                  o_ready,
    output logic                  o_refreshActive,
    output logic [((BANKS > 1) ? $clog2(BANKS) : 1)-1:0] o_refreshBank,
    output logic                  o_cmdError
);

    localparam int BW = (BANKS > 1) ? $clog2(BANKS) : 1;
    localparam int IW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_REFRESH = 1'b1;

    logic [0:0]            r_state;
    logic                  r_refreshPending;
    logic [IW-1:0]         r_intervalCount;
    logic [RW-1:0]         r_refreshCount;
    logic [BW-1:0]         r_refreshBank;
    logic                  r_cmdError;
    logic [READ_LATENCY-1:0] r_pipeValid;
    logic [DATA_WIDTH-1:0] r_pipeData [READ_LATENCY];
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic w_ready;
    logic w_accept;
    logic w_acceptRead;
    logic w_acceptWrite;
    logic w_cmdConflict;
    logic w_wrap;
    logic w_request;
    logic w_startRefresh;
    logic w_refreshDone;
    logic [DATA_WIDTH-1:0] w_memRead;

    // Ready comes only from registers so requesters never see a combinational path
    assign w_ready        = (r_state == ST_IDLE) && !r_refreshPending;
    assign w_accept       = i_enable && w_ready && (i_read ^ i_write);
    assign w_acceptRead   = w_accept && i_read;
    assign w_acceptWrite  = w_accept && i_write;
    assign w_cmdConflict  = i_enable && w_ready && i_read && i_write;
    assign w_wrap         = (r_intervalCount == IW'(REFRESH_INTERVAL - 1));
    assign w_request      = w_wrap || i_refresh;
    assign w_startRefresh = (r_state == ST_IDLE) && (r_refreshPending || w_request);
    assign w_refreshDone  = (r_refreshCount == RW'(REFRESH_CYCLES - 1));
    assign w_memRead      = r_mem[i_address];

    assign o_ready         = w_ready;
    assign o_refreshActive = (r_state == ST_REFRESH);
    assign o_refreshBank   = r_refreshBank;
    assign o_cmdError      = r_cmdError;
    assign o_readValid     = r_pipeValid[READ_LATENCY-1];
    assign o_readData      = r_pipeData[READ_LATENCY-1];

    // Refresh scheduler: interval counter, one-deep pending request, refresh timing and bank rotation
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state          <= ST_IDLE;
            r_refreshPending <= 1'b0;
            r_intervalCount  <= '0;
            r_refreshCount   <= '0;
            r_refreshBank    <= BW'(BANKS - 1);
        end else begin
            if (w_wrap || w_startRefresh) begin
                r_intervalCount <= '0;
            end else begin
                r_intervalCount <= r_intervalCount + 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_startRefresh) begin
                        r_state          <= ST_REFRESH;
                        r_refreshPending <= 1'b0;
                        r_refreshCount   <= '0;
                        if (r_refreshBank == BW'(BANKS - 1)) begin
                            r_refreshBank <= '0;
                        end else begin
                            r_refreshBank <= r_refreshBank + 1'b1;
                        end
                    end
                end
                default: begin
                    if (w_request) begin
                        r_refreshPending <= 1'b1;
                    end
                    if (w_refreshDone) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_refreshCount <= r_refreshCount + 1'b1;
                    end
                end
            endcase
        end
    end

    // Storage array keeps its contents across reset
    always_ff @(posedge i_clk) begin
        if (w_acceptWrite) begin
            r_mem[i_address] <= i_writeData;
        end
    end

    // Read latency pipeline; data stages only move with valid so the output word holds between strobes
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pipeValid <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_pipeData[i] <= '0;
            end
        end else begin
            r_pipeValid[0] <= w_acceptRead;
            if (w_acceptRead) begin
                r_pipeData[0] <= w_memRead;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_pipeValid[i] <= r_pipeValid[i-1];
                if (r_pipeValid[i-1]) begin
                    r_pipeData[i] <= r_pipeData[i-1];
                end
            end
        end
    end

    // Sticky flag for a command that asks for read and write at once
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cmdError <= 1'b0;
        end else if (w_cmdConflict) begin
            r_cmdError <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ic_sdr_qsram_banked.sv
// Directed self-checking bench for ic_sdr_qsram_banked with default parameters.
module tb_ic_sdr_qsram_banked;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       read = 1'b0;
    logic       write = 1'b0;
    logic       refresh = 1'b0;
    logic [9:0] address = '0;
    logic [8:0] writeData = '0;
    logic [8:0] readData;
    logic       readValid;
    logic       ready;
    logic       refreshActive;
    logic [1:0] refreshBank;
    logic       cmdError;

    int checks = 0;
    int errors = 0;
    logic [8:0] preload [8];

    ic_sdr_qsram_banked dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_enable        (enable),
        .i_read          (read),
        .i_write         (write),
        .i_refresh       (refresh),
        .i_address       (address),
        .i_writeData     (writeData),
        .o_readData      (readData),
        .o_readValid     (readValid),
        .o_ready         (ready),
        .o_refreshActive (refreshActive),
        .o_refreshBank   (refreshBank),
        .o_cmdError      (cmdError)
    );

    // Free-running 10 ns clock
    always #5 clk = ~clk;

    // Hard stop in case something stalls the directed sequence
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Called at a negedge; waits for Ready, issues one command for one cycle, returns at the next negedge
    task automatic applyStimulus(input logic rd, input logic wr, input logic [9:0] addr, input logic [8:0] data);
        int waitCount = 0;
        while (!ready && waitCount < 100) begin
            @(negedge clk);
            waitCount++;
        end
        if (!ready) checkOutput("readyTimeout", {31'd0, ready}, 32'd1);
        enable    = 1'b1;
        read      = rd;
        write     = wr;
        address   = addr;
        writeData = data;
        @(posedge clk);
        @(negedge clk);
        enable = 1'b0;
        read   = 1'b0;
        write  = 1'b0;
    endtask

    task automatic readCheck(input string tag, input logic [9:0] addr, input logic [8:0] expected);
        applyStimulus(1'b1, 1'b0, addr, 9'd0);
        checkOutput({tag, "_earlyValid"}, {31'd0, readValid}, 32'd0);
        @(negedge clk);
        checkOutput({tag, "_valid"}, {31'd0, readValid}, 32'd1);
        checkOutput({tag, "_data"}, {23'd0, readData}, {23'd0, expected});
    endtask

    // Assert reset for one edge and release at a negedge (start of cycle 1)
    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) preload[i] = 9'(9'h0A0 + i * 37);

        // Reset values while held in reset
        #12;
        checkOutput("rst_ready", {31'd0, ready}, 32'd1);
        checkOutput("rst_valid", {31'd0, readValid}, 32'd0);
        checkOutput("rst_data", {23'd0, readData}, 32'd0);
        checkOutput("rst_active", {31'd0, refreshActive}, 32'd0);
        checkOutput("rst_bank", {30'd0, refreshBank}, 32'd3);
        checkOutput("rst_err", {31'd0, cmdError}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rel_ready", {31'd0, ready}, 32'd1);

        // Write then read the same word on consecutive cycles
        applyStimulus(1'b0, 1'b1, 10'h003, 9'h1A5);
        readCheck("wr_rd", 10'h003, 9'h1A5);
        @(negedge clk);
        checkOutput("hold_valid", {31'd0, readValid}, 32'd0);
        checkOutput("hold_data", {23'd0, readData}, 32'h1A5);

        // Automatic refresh timing from a fresh reset
        doReset();
        repeat (63) @(negedge clk);
        checkOutput("c64_ready", {31'd0, ready}, 32'd1);
        checkOutput("c64_active", {31'd0, refreshActive}, 32'd0);
        @(negedge clk);
        checkOutput("c65_ready", {31'd0, ready}, 32'd0);
        checkOutput("c65_active", {31'd0, refreshActive}, 32'd1);
        checkOutput("c65_bank", {30'd0, refreshBank}, 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("c68_active", {31'd0, refreshActive}, 32'd1);
        @(negedge clk);
        checkOutput("c69_ready", {31'd0, ready}, 32'd1);
        checkOutput("c69_active", {31'd0, refreshActive}, 32'd0);

        // Preload words 0..7 and the refresh-write target
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 10'(i), preload[i]);
        applyStimulus(1'b0, 1'b1, 10'h020, 9'h011);

        // Conflicting read+write command
        applyStimulus(1'b0, 1'b1, 10'h010, 9'h055);
        applyStimulus(1'b1, 1'b1, 10'h010, 9'h1FF);
        checkOutput("conf_valid1", {31'd0, readValid}, 32'd0);
        checkOutput("conf_err", {31'd0, cmdError}, 32'd1);
        @(negedge clk);
        checkOutput("conf_valid2", {31'd0, readValid}, 32'd0);
        readCheck("conf_word", 10'h010, 9'h055);
        checkOutput("conf_sticky", {31'd0, cmdError}, 32'd1);

        // Manual refresh with a write held across it
        doReset();
        checkOutput("err_cleared", {31'd0, cmdError}, 32'd0);
        refresh = 1'b1;
        @(negedge clk);
        refresh = 1'b0;
        checkOutput("man_active", {31'd0, refreshActive}, 32'd1);
        checkOutput("man_ready", {31'd0, ready}, 32'd0);
        checkOutput("man_bank", {30'd0, refreshBank}, 32'd0);
        enable = 1'b1; write = 1'b1; address = 10'h020; writeData = 9'h0FF;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 3) checkOutput("man_r4_ready", {31'd0, ready}, 32'd0);
            if (k == 4) checkOutput("man_r5_ready", {31'd0, ready}, 32'd1);
        end
        enable = 1'b0; write = 1'b0;
        readCheck("man_rd", 10'h020, 9'h0FF);

        // Reset while a read is in flight during refresh
        doReset();
        enable = 1'b1; read = 1'b1; address = 10'h003; refresh = 1'b1;
        @(negedge clk);
        enable = 1'b0; read = 1'b0; refresh = 1'b0;
        checkOutput("flush_active", {31'd0, refreshActive}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("flush_valid", {31'd0, readValid}, 32'd0);
        checkOutput("flush_data", {23'd0, readData}, 32'd0);
        checkOutput("flush_act0", {31'd0, refreshActive}, 32'd0);
        checkOutput("flush_bank", {30'd0, refreshBank}, 32'd3);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("flush_ready", {31'd0, ready}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            checkOutput("flush_noValid", {31'd0, readValid}, 32'd0);
            @(negedge clk);
        end

        // Back-to-back reads of words 0..7
        for (int j = 0; j < 11; j++) begin
            if (j >= 2 && j < 10) begin
                checkOutput("b2b_valid", {31'd0, readValid}, 32'd1);
                checkOutput("b2b_data", {23'd0, readData}, {23'd0, preload[j-2]});
            end
            if (j == 10) checkOutput("b2b_end", {31'd0, readValid}, 32'd0);
            if (j < 8) begin
                checkOutput("b2b_ready", {31'd0, ready}, 32'd1);
                enable = 1'b1; read = 1'b1; address = 10'(j);
            end else begin
                enable = 1'b0; read = 1'b0;
            end
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
